// File: rtl/zap_regf_pkg.sv
// rtl/zap_regf_pkg.sv - shared register-file constants and write-back entry type
//
// Purpose: phase encoding shared by the write-back queue and the double-pumped
// register file, default address/data widths, and the write-back entry struct.
package zap_regf_pkg;

  // Phase encoding; both the queue and the register file reset into READ_PH.
  localparam logic READ_PH  = 1'b0;
  localparam logic WRITE_PH = 1'b1;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regf_byp_match.sv
// rtl/regf_byp_match.sv - newest-wins bypass search for one read port
//
// Purpose: search the queued writes and the issue register for rd_addr.
// Ports:
//   rd_addr                  read address to match
//   q_addr/q_data            physical queue storage
//   head/count               valid region of the queue (head = oldest)
//   iss_valid                issue register is live (o_wen of the queue)
//   iss_addr_*/iss_data_*    issue register contents, port B newer than A
//   hit/data                 match flag and newest matching data (0 on miss)
module regf_byp_match
  import zap_regf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] q_addr [DEPTH],
  input  logic [DW-1:0] q_data [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [PW:0]   count,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr_a,
  input  logic [AW-1:0] iss_addr_b,
  input  logic [DW-1:0] iss_data_a,
  input  logic [DW-1:0] iss_data_b,
  output logic          hit,
  output logic [DW-1:0] data
);

  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Scan oldest to newest so that the last match written wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (iss_valid && iss_addr_a == rd_addr) begin
      hit  = 1'b1;
      data = iss_data_a;
    end
    if (iss_valid && iss_addr_b == rd_addr) begin
      hit  = 1'b1;
      data = iss_data_b;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count && q_addr[idx] == rd_addr) begin
        hit  = 1'b1;
        data = q_data[idx];
      end
    end
  end

endmodule

// File: rtl/regf_wb_queue.sv
// rtl/regf_wb_queue.sv - write-back staging queue with bypass for the 4R/2W register file
//
// Purpose: accept up to two writes per cycle, issue up to two writes per WRITE
// phase, and give newest-wins bypass data to the four read ports.
// Ports:
//   i_clk_2x, i_reset                  clock, synchronous active-high reset
//   i_wr_valid/addr/data_a, _b         incoming writes, B newer than A
//   o_ready, o_drop, o_empty           flow control and status
//   o_wen, o_wr_addr_*, o_wr_data_*    register-file write port (issue register)
//   i_rd_addr_a..d                     register-file read addresses
//   o_byp_hit_a..d, o_byp_data_a..d    bypass result per read port
module regf_wb_queue
  import zap_regf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          i_clk_2x,
  input  logic          i_reset,
  input  logic          i_wr_valid_a,
  input  logic [AW-1:0] i_wr_addr_a,
  input  logic [DW-1:0] i_wr_data_a,
  input  logic          i_wr_valid_b,
  input  logic [AW-1:0] i_wr_addr_b,
  input  logic [DW-1:0] i_wr_data_b,
  output logic          o_ready,
  output logic          o_drop,
  output logic          o_empty,
  output logic          o_wen,
  output logic [AW-1:0] o_wr_addr_a,
  output logic [AW-1:0] o_wr_addr_b,
  output logic [DW-1:0] o_wr_data_a,
  output logic [DW-1:0] o_wr_data_b,
  input  logic [AW-1:0] i_rd_addr_a,
  input  logic [AW-1:0] i_rd_addr_b,
  input  logic [AW-1:0] i_rd_addr_c,
  input  logic [AW-1:0] i_rd_addr_d,
  output logic          o_byp_hit_a,
  output logic          o_byp_hit_b,
  output logic          o_byp_hit_c,
  output logic          o_byp_hit_d,
  output logic [DW-1:0] o_byp_data_a,
  output logic [DW-1:0] o_byp_data_b,
  output logic [DW-1:0] o_byp_data_c,
  output logic [DW-1:0] o_byp_data_d
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic          phase;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];

  logic          push_a, push_b;
  logic [PW-1:0] tail_b, head_n1;
  logic [1:0]    n_pop;
  logic          same_addr;

  always_comb begin
    o_ready   = (count <= READY_MAX);
    o_empty   = (count == '0) && !o_wen;
    push_a    = o_ready && i_wr_valid_a;
    push_b    = o_ready && i_wr_valid_b;
    // B lands right after A, or in A's slot when A is absent.
    tail_b    = tail + PW'(push_a);
    head_n1   = head + PW'(1);
    same_addr = (q_addr[head] == q_addr[head_n1]);
    n_pop     = 2'd0;
    if (phase == READ_PH) begin
      if (count == CW'(1))      n_pop = 2'd1;
      else if (count >= CW'(2)) n_pop = 2'd2;
    end
  end

  // Queue storage needs no reset: validity is defined by head/count.
  always_ff @(posedge i_clk_2x) begin
    if (push_a) begin
      q_addr[tail] <= i_wr_addr_a;
      q_data[tail] <= i_wr_data_a;
    end
    if (push_b) begin
      q_addr[tail_b] <= i_wr_addr_b;
      q_data[tail_b] <= i_wr_data_b;
    end
  end

  always_ff @(posedge i_clk_2x) begin
    if (i_reset) begin
      phase       <= READ_PH;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      o_drop      <= 1'b0;
      o_wen       <= 1'b0;
      o_wr_addr_a <= '0;
      o_wr_addr_b <= '0;
      o_wr_data_a <= '0;
      o_wr_data_b <= '0;
    end else begin
      phase  <= ~phase;
      o_drop <= (i_wr_valid_a || i_wr_valid_b) && !o_ready;
      tail   <= tail + PW'(push_a) + PW'(push_b);
      head   <= head + PW'(n_pop);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(n_pop);
      o_wen  <= (n_pop != 2'd0);
      if (n_pop == 2'd1) begin
        o_wr_addr_a <= q_addr[head];
        o_wr_addr_b <= q_addr[head];
        o_wr_data_a <= q_data[head];
        o_wr_data_b <= q_data[head];
      end else if (n_pop == 2'd2) begin
        // Same address twice: the older write is dead, issue the newer on both ports.
        o_wr_addr_a <= same_addr ? q_addr[head_n1] : q_addr[head];
        o_wr_data_a <= same_addr ? q_data[head_n1] : q_data[head];
        o_wr_addr_b <= q_addr[head_n1];
        o_wr_data_b <= q_data[head_n1];
      end
    end
  end

  regf_byp_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp_a (
    .rd_addr(i_rd_addr_a), .q_addr(q_addr), .q_data(q_data), .head(head), .count(count),
    .iss_valid(o_wen), .iss_addr_a(o_wr_addr_a), .iss_addr_b(o_wr_addr_b),
    .iss_data_a(o_wr_data_a), .iss_data_b(o_wr_data_b), .hit(o_byp_hit_a), .data(o_byp_data_a));

  regf_byp_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp_b (
    .rd_addr(i_rd_addr_b), .q_addr(q_addr), .q_data(q_data), .head(head), .count(count),
    .iss_valid(o_wen), .iss_addr_a(o_wr_addr_a), .iss_addr_b(o_wr_addr_b),
    .iss_data_a(o_wr_data_a), .iss_data_b(o_wr_data_b), .hit(o_byp_hit_b), .data(o_byp_data_b));

  regf_byp_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp_c (
    .rd_addr(i_rd_addr_c), .q_addr(q_addr), .q_data(q_data), .head(head), .count(count),
    .iss_valid(o_wen), .iss_addr_a(o_wr_addr_a), .iss_addr_b(o_wr_addr_b),
    .iss_data_a(o_wr_data_a), .iss_data_b(o_wr_data_b), .hit(o_byp_hit_c), .data(o_byp_data_c));

  regf_byp_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp_d (
    .rd_addr(i_rd_addr_d), .q_addr(q_addr), .q_data(q_data), .head(head), .count(count),
    .iss_valid(o_wen), .iss_addr_a(o_wr_addr_a), .iss_addr_b(o_wr_addr_b),
    .iss_data_a(o_wr_data_a), .iss_data_b(o_wr_data_b), .hit(o_byp_hit_d), .data(o_byp_data_d));

endmodule

// File: tb/tb_regf_wb_queue.sv
// tb/tb_regf_wb_queue.sv - scoreboard testbench for regf_wb_queue
module tb_regf_wb_queue;
  import zap_regf_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          va = 1'b0, vb = 1'b0;
  logic [AW-1:0] aa = '0, ab = '0;
  logic [DW-1:0] da = '0, db = '0;
  logic [AW-1:0] ra [4] = '{default: '0};
  logic          o_ready, o_drop, o_empty, o_wen;
  logic [AW-1:0] o_wr_addr_a, o_wr_addr_b;
  logic [DW-1:0] o_wr_data_a, o_wr_data_b;
  logic          hit [4];
  logic [DW-1:0] bdat [4];

  always #5 clk = ~clk;

  regf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk_2x(clk), .i_reset(rst),
    .i_wr_valid_a(va), .i_wr_addr_a(aa), .i_wr_data_a(da),
    .i_wr_valid_b(vb), .i_wr_addr_b(ab), .i_wr_data_b(db),
    .o_ready(o_ready), .o_drop(o_drop), .o_empty(o_empty), .o_wen(o_wen),
    .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b),
    .o_wr_data_a(o_wr_data_a), .o_wr_data_b(o_wr_data_b),
    .i_rd_addr_a(ra[0]), .i_rd_addr_b(ra[1]), .i_rd_addr_c(ra[2]), .i_rd_addr_d(ra[3]),
    .o_byp_hit_a(hit[0]), .o_byp_hit_b(hit[1]), .o_byp_hit_c(hit[2]), .o_byp_hit_d(hit[3]),
    .o_byp_data_a(bdat[0]), .o_byp_data_b(bdat[1]), .o_byp_data_c(bdat[2]), .o_byp_data_d(bdat[3])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes in arrival order, plus the expected issue stream.
  wb_entry_t mq [$];
  wb_entry_t exp_a [$];
  wb_entry_t exp_b [$];
  wb_entry_t mia, mib;
  logic      mphase, mwen, mdrop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) begin
        h = 1'b1;
        d = mq[i].data;
        return;
      end
    end
    if (mwen && mib.addr == a) begin
      h = 1'b1;
      d = mib.data;
    end else if (mwen && mia.addr == a) begin
      h = 1'b1;
      d = mia.data;
    end
  endfunction

  task automatic model_step();
    wb_entry_t e0, e1;
    logic rdy;
    if (rst) begin
      mq.delete(); exp_a.delete(); exp_b.delete();
      mphase = READ_PH; mwen = 1'b0; mdrop = 1'b0; mia = '0; mib = '0;
    end else begin
      rdy = (DEPTH - mq.size()) >= 2;
      mwen = 1'b0;
      if (mphase == READ_PH && mq.size() == 1) begin
        e0 = mq.pop_front();
        mia = e0; mib = e0; mwen = 1'b1;
      end else if (mphase == READ_PH && mq.size() >= 2) begin
        e0 = mq.pop_front();
        e1 = mq.pop_front();
        mia = (e0.addr == e1.addr) ? e1 : e0;
        mib = e1; mwen = 1'b1;
      end
      if (mwen) begin
        exp_a.push_back(mia);
        exp_b.push_back(mib);
      end
      if (rdy) begin
        if (va) mq.push_back('{addr: aa, data: da});
        if (vb) mq.push_back('{addr: ab, data: db});
      end
      mdrop  = !rdy && (va || vb);
      mphase = ~mphase;
    end
  endtask

  initial begin
    mphase = READ_PH; mwen = 1'b0; mdrop = 1'b0; mia = '0; mib = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each write issue.
  initial begin
    wb_entry_t ea, eb;
    logic h;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      chk("wen", o_wen, mwen);
      if (o_wen) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected at %0t: got write %0h expected none", $time, o_wr_addr_a);
        end else begin
          ea = exp_a.pop_front();
          eb = exp_b.pop_front();
          chk("wr_addr_a", o_wr_addr_a, ea.addr);
          chk("wr_data_a", o_wr_data_a, ea.data);
          chk("wr_addr_b", o_wr_addr_b, eb.addr);
          chk("wr_data_b", o_wr_data_b, eb.data);
        end
      end
      chk("ready", o_ready, (DEPTH - mq.size()) >= 2);
      chk("drop", o_drop, mdrop);
      chk("empty", o_empty, (mq.size() == 0) && !mwen);
      for (int p = 0; p < 4; p++) begin
        lookup(ra[p], h, d);
        chk($sformatf("byp_hit%0d", p), hit[p], h);
        chk($sformatf("byp_data%0d", p), bdat[p], d);
      end
    end
  end

  task automatic drive(input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                       input logic b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d);
    @(posedge clk);
    #1;
    va = a_v; aa = a_a; da = a_d;
    vb = b_v; ab = b_a; db = b_d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    // single write duplicated on both ports
    drive(1'b1, 6'd3, 32'h1111_1111, 1'b0, '0, '0);
    idle(4);
    // pair to distinct addresses
    drive(1'b1, 6'd1, 32'hA, 1'b1, 6'd2, 32'hB);
    idle(4);
    // same-address pair merges; bypass r5 before issue
    ra[0] = 6'd5;
    drive(1'b1, 6'd5, 32'h1, 1'b1, 6'd5, 32'h2);
    idle(4);
    // fill to full, then overflow
    for (int i = 0; i < 6; i++)
      drive(1'b1, 6'(8 + 2 * i), 32'h100 + i, 1'b1, 6'(9 + 2 * i), 32'h200 + i);
    idle(10);
    // r7 written twice in separate cycles
    ra[1] = 6'd7;
    drive(1'b1, 6'd7, 32'h3, 1'b0, '0, '0);
    drive(1'b1, 6'd7, 32'h4, 1'b1, 6'd20, 32'h55);
    drive(1'b1, 6'd21, 32'h66, 1'b1, 6'd22, 32'h77);
    idle(6);
    // reset while writes are queued and one is being issued
    for (int i = 0; i < 3; i++)
      drive(1'b1, 6'(30 + i), 32'h300 + i, 1'b1, 6'(40 + i), 32'h400 + i);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      seen = o_wen;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wen_timeout: got no write enable expected one within 10 cycles");
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    // randomized traffic over a small address range to force collisions
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 4; p++) ra[p] = 6'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, 6'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 6'($urandom_range(0, 7)), $urandom);
    end
    rst = 1'b0;
    idle(20);
    chk("scoreboard_drained", exp_a.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
